// File: rtl/fetch_issue_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one outstanding I-cache request,
// queues returned instructions and hands the queue head to the decoder.
module fetch_issue_ctrl #(
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  output logic                           icache_req_valid,
  output logic [31:0]                    icache_req_addr,
  input  logic                           icache_resp_valid,
  input  logic [31:0]                    icache_resp_instr,
  output logic                           issue_valid,
  output logic [31:0]                    issue_instr,
  output logic [31:0]                    issue_pc,
  input  logic                           issue_ready,
  input  logic                           redirect_valid,
  input  logic [31:0]                    redirect_pc,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_fetch_pc;
  logic [31:0]     w_fetch_pc_nxt;
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_instr_q [QUEUE_DEPTH];
  logic [31:0]     r_pc_q    [QUEUE_DEPTH];

  logic            w_full;
  logic            w_req;
  logic            w_push;
  logic            w_pop;
  logic            w_flush;
  logic            w_is_jal;
  logic [31:0]     w_jimm;
  logic [31:0]     w_seq_pc;

  assign w_full  = (r_count == CW'(QUEUE_DEPTH));
  assign w_flush = rdy_in & redirect_valid;

  // Request is gated by reset so nothing escapes while the PC is forced
  assign w_req = (r_state == S_IDLE) & rdy_in & ~redirect_valid
               & ~w_full & ~rst_in;

  assign w_push = rdy_in & ~redirect_valid & (r_state == S_WAIT)
                & icache_resp_valid;
  assign w_pop  = rdy_in & ~redirect_valid & issue_valid & issue_ready;

  assign w_is_jal = (icache_resp_instr[6:0] == OP_JAL);
  assign w_jimm   = {{12{icache_resp_instr[31]}},
                     icache_resp_instr[19:12],
                     icache_resp_instr[20],
                     icache_resp_instr[30:21],
                     1'b0};
  assign w_seq_pc = w_is_jal ? (r_fetch_pc + w_jimm)
                             : (r_fetch_pc + 32'd4);

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    if (rdy_in) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (icache_resp_valid)   w_state_nxt = S_IDLE;
          else if (redirect_valid) w_state_nxt = S_DROP;
        end
        S_DROP: begin
          if (icache_resp_valid) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (redirect_valid)  w_fetch_pc_nxt = redirect_pc;
      else if (w_push)     w_fetch_pc_nxt = w_seq_pc;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      if (w_push & ~w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop & ~w_push) r_count <= r_count - CW'(1);
    end
  end

  // Storage needs no reset; count gates every read
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_instr_q[r_tail] <= icache_resp_instr;
      r_pc_q[r_tail]    <= r_fetch_pc;
    end
  end

  assign icache_req_valid = w_req;
  assign icache_req_addr  = r_fetch_pc;
  assign issue_valid      = (r_count != '0);
  assign issue_instr      = issue_valid ? r_instr_q[r_head] : 32'h0;
  assign issue_pc         = issue_valid ? r_pc_q[r_head]    : 32'h0;
  assign queue_count      = r_count;

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Directed bench for fetch_issue_ctrl: sequencing, JAL, full queue,
// redirects, freeze and async reset.
module tb_fetch_issue_ctrl;

  localparam logic [31:0] ADDI = 32'h00100093;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_instr;
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic [31:0] issue_pc;
  logic        issue_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [3:0]  queue_count;

  int n_pass;
  int n_total;

  fetch_issue_ctrl #(
    .QUEUE_DEPTH(8),
    .RESET_PC(32'h0)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .icache_req_valid (icache_req_valid),
    .icache_req_addr  (icache_req_addr),
    .icache_resp_valid(icache_resp_valid),
    .icache_resp_instr(icache_resp_instr),
    .issue_valid      (issue_valid),
    .issue_instr      (issue_instr),
    .issue_pc         (issue_pc),
    .issue_ready      (issue_ready),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .queue_count      (queue_count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    icache_resp_valid = 1'b0;
    icache_resp_instr = 32'h0;
    issue_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    #1;
  endtask

  // One request/response pair with 1-cycle latency (setup only)
  task automatic fetch_one(input logic [31:0] ins);
    icache_resp_valid = 1'b0;
    @(posedge clk_in); #1;
    icache_resp_valid = 1'b1;
    icache_resp_instr = ins;
    @(posedge clk_in); #1;
    icache_resp_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    icache_resp_valid = 1'b0;
    icache_resp_instr = 32'h0;
    issue_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    @(posedge clk_in); #2;
    n_total++;
    if (icache_req_valid !== 1'b0)
      $display("FAIL rst_req: got %b want 0", icache_req_valid);
    else n_pass++;
    n_total++;
    if (issue_valid !== 1'b0 || queue_count !== 4'd0)
      $display("FAIL rst_q: got v=%b c=%0d want 0/0",
               issue_valid, queue_count);
    else n_pass++;
    n_total++;
    if (icache_req_addr !== 32'h0 || issue_pc !== 32'h0)
      $display("FAIL rst_pc: got %h/%h want 0/0",
               icache_req_addr, issue_pc);
    else n_pass++;
    rst_in = 1'b0;
    #1;
    n_total++;
    if (icache_req_valid !== 1'b1)
      $display("FAIL rst_first_req: got %b want 1", icache_req_valid);
    else n_pass++;
  endtask

  task automatic test_sequential();
    do_reset();
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'(4 * k))
        $display("FAIL seq_req%0d: got %b/%h want 1/%h", k,
                 icache_req_valid, icache_req_addr, 32'(4 * k));
      else n_pass++;
      if (k > 0) begin
        n_total++;
        if (issue_valid !== 1'b1 || issue_pc !== 32'(4 * (k - 1))
            || issue_instr !== ADDI || queue_count !== 4'd1)
          $display("FAIL seq_issue%0d: got %b/%h/%h/%0d want 1/%h/%h/1",
                   k, issue_valid, issue_pc, issue_instr, queue_count,
                   32'(4 * (k - 1)), ADDI);
        else n_pass++;
      end
      if (k < 3) begin
        @(posedge clk_in); #1;
        icache_resp_valid = 1'b1;
        icache_resp_instr = ADDI;
        #1;
        n_total++;
        if (icache_req_valid !== 1'b0 || queue_count !== 4'd0)
          $display("FAIL seq_wait%0d: got %b/%0d want 0/0", k,
                   icache_req_valid, queue_count);
        else n_pass++;
        @(posedge clk_in); #1;
        icache_resp_valid = 1'b0;
        #1;
      end
    end
  endtask

  task automatic test_jal();
    do_reset();
    issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) fetch_one(ADDI);
    n_total++;
    if (icache_req_addr !== 32'h10)
      $display("FAIL jal_pre: got %h want 00000010", icache_req_addr);
    else n_pass++;
    fetch_one(32'h0200006F);
    n_total++;
    if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h30)
      $display("FAIL jal_fwd: got %b/%h want 1/00000030",
               icache_req_valid, icache_req_addr);
    else n_pass++;
    n_total++;
    if (issue_pc !== 32'h10 || issue_instr !== 32'h0200006F)
      $display("FAIL jal_issue: got %h/%h want 00000010/0200006f",
               issue_pc, issue_instr);
    else n_pass++;
    for (int k = 0; k < 4; k++) fetch_one(ADDI);
    n_total++;
    if (icache_req_addr !== 32'h40)
      $display("FAIL jal_mid: got %h want 00000040", icache_req_addr);
    else n_pass++;
    fetch_one(32'hFF1FF06F);
    n_total++;
    if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h30)
      $display("FAIL jal_bwd: got %b/%h want 1/00000030",
               icache_req_valid, icache_req_addr);
    else n_pass++;
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int k = 0; k < 8; k++) fetch_one(32'h13 | (k << 20));
    n_total++;
    if (queue_count !== 4'd8 || icache_req_valid !== 1'b0)
      $display("FAIL full_cnt: got %0d/%b want 8/0",
               queue_count, icache_req_valid);
    else n_pass++;
    @(posedge clk_in); #2;
    n_total++;
    if (icache_req_valid !== 1'b0 || issue_pc !== 32'h0)
      $display("FAIL full_hold: got %b/%h want 0/00000000",
               icache_req_valid, issue_pc);
    else n_pass++;
    issue_ready = 1'b1;
    @(posedge clk_in); #1;
    issue_ready = 1'b0;
    #1;
    n_total++;
    if (queue_count !== 4'd7 || icache_req_valid !== 1'b1
        || icache_req_addr !== 32'h20)
      $display("FAIL full_pop: got %0d/%b/%h want 7/1/00000020",
               queue_count, icache_req_valid, icache_req_addr);
    else n_pass++;
    fetch_one(32'h13 | (8 << 20));
    n_total++;
    if (queue_count !== 4'd8)
      $display("FAIL full_refill: got %0d want 8", queue_count);
    else n_pass++;
    issue_ready = 1'b1;
    #1;
    for (int j = 0; j < 8; j++) begin
      n_total++;
      if (issue_valid !== 1'b1 || issue_pc !== 32'(4 * (j + 1))
          || issue_instr !== (32'h13 | 32'((j + 1) << 20)))
        $display("FAIL wrap_pop%0d: got %b/%h/%h want 1/%h/%h", j,
                 issue_valid, issue_pc, issue_instr, 32'(4 * (j + 1)),
                 32'h13 | 32'((j + 1) << 20));
      else n_pass++;
      @(posedge clk_in); #2;
    end
    n_total++;
    if (issue_valid !== 1'b0 || queue_count !== 4'd0)
      $display("FAIL wrap_empty: got %b/%0d want 0/0",
               issue_valid, queue_count);
    else n_pass++;
  endtask

  task automatic test_redirect_flight();
    do_reset();
    issue_ready = 1'b1;
    fetch_one(ADDI);
    fetch_one(ADDI);
    n_total++;
    if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h8)
      $display("FAIL rf_req: got %b/%h want 1/00000008",
               icache_req_valid, icache_req_addr);
    else n_pass++;
    @(posedge clk_in); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    n_total++;
    if (icache_req_valid !== 1'b0)
      $display("FAIL rf_redir_req: got %b want 0", icache_req_valid);
    else n_pass++;
    @(posedge clk_in); #1;
    redirect_valid = 1'b0;
    #1;
    n_total++;
    if (icache_req_valid !== 1'b0 || icache_req_addr !== 32'h100)
      $display("FAIL rf_drop: got %b/%h want 0/00000100",
               icache_req_valid, icache_req_addr);
    else n_pass++;
    @(posedge clk_in); #1;
    icache_resp_valid = 1'b1;
    icache_resp_instr = ADDI;
    #1;
    n_total++;
    if (icache_req_valid !== 1'b0)
      $display("FAIL rf_drop_resp: got %b want 0", icache_req_valid);
    else n_pass++;
    @(posedge clk_in); #1;
    icache_resp_valid = 1'b0;
    #1;
    n_total++;
    if (queue_count !== 4'd0 || icache_req_valid !== 1'b1
        || icache_req_addr !== 32'h100)
      $display("FAIL rf_after: got %0d/%b/%h want 0/1/00000100",
               queue_count, icache_req_valid, icache_req_addr);
    else n_pass++;
  endtask

  task automatic test_redirect_coincident();
    do_reset();
    for (int k = 0; k < 3; k++) fetch_one(ADDI);
    n_total++;
    if (queue_count !== 4'd3 || icache_req_addr !== 32'hC)
      $display("FAIL rc_pre: got %0d/%h want 3/0000000c",
               queue_count, icache_req_addr);
    else n_pass++;
    @(posedge clk_in); #1;
    icache_resp_valid = 1'b1;
    icache_resp_instr = ADDI;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    issue_ready = 1'b1;
    #1;
    n_total++;
    if (icache_req_valid !== 1'b0 || issue_valid !== 1'b1)
      $display("FAIL rc_cycle: got %b/%b want 0/1",
               icache_req_valid, issue_valid);
    else n_pass++;
    @(posedge clk_in); #1;
    icache_resp_valid = 1'b0;
    redirect_valid = 1'b0;
    issue_ready = 1'b0;
    #1;
    n_total++;
    if (queue_count !== 4'd0 || issue_valid !== 1'b0
        || icache_req_valid !== 1'b1 || icache_req_addr !== 32'h100)
      $display("FAIL rc_after: got %0d/%b/%b/%h want 0/0/1/00000100",
               queue_count, issue_valid, icache_req_valid, icache_req_addr);
    else n_pass++;
  endtask

  task automatic test_freeze_reset();
    do_reset();
    fetch_one(ADDI);
    fetch_one(ADDI);
    @(posedge clk_in); #1;
    rdy_in = 1'b0;
    issue_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++;
      if (queue_count !== 4'd2 || icache_req_valid !== 1'b0
          || issue_pc !== 32'h0 || icache_req_addr !== 32'h8)
        $display("FAIL frz%0d: got %0d/%b/%h/%h want 2/0/0/8", k,
                 queue_count, icache_req_valid, issue_pc, icache_req_addr);
      else n_pass++;
      @(posedge clk_in); #1;
    end
    rdy_in = 1'b1;
    issue_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    n_total++;
    if (queue_count !== 4'd2 || icache_req_valid !== 1'b0
        || icache_req_addr !== 32'h8)
      $display("FAIL frz_wait: got %0d/%b/%h want 2/0/00000008",
               queue_count, icache_req_valid, icache_req_addr);
    else n_pass++;
    #1;
    rst_in = 1'b1;
    #1;
    n_total++;
    if (queue_count !== 4'd0 || issue_valid !== 1'b0
        || icache_req_valid !== 1'b0 || icache_req_addr !== 32'h0)
      $display("FAIL arst: got %0d/%b/%b/%h want 0/0/0/0",
               queue_count, issue_valid, icache_req_valid, icache_req_addr);
    else n_pass++;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    #1;
    n_total++;
    if (icache_req_valid !== 1'b1 || icache_req_addr !== 32'h0)
      $display("FAIL arst_req: got %b/%h want 1/00000000",
               icache_req_valid, icache_req_addr);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_sequential();
    test_jal();
    test_full_wrap();
    test_redirect_flight();
    test_redirect_coincident();
    test_freeze_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_issue_ctrl.md
Name:
fetch_issue_ctrl

Overview:
- Fetch sequencer feeding the instruction decoder.
- Owns the fetch PC and issues one-at-a-time requests to the instruction cache.
- Buffers returned instructions with their PCs in a circular queue and presents the queue head to the decoder with a valid/ready handshake.
- Pre-decodes JAL to redirect fetch early; flushes on back-end redirects.

Parameters:
- QUEUE_DEPTH, 8, instruction queue entries; power of two, at least 2.
- RESET_PC, 32'h0, fetch PC after reset.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- rdy_in  input  1  global enable; 0 freezes all state.
- icache_req_valid  output  1  single-cycle fetch request pulse.
- icache_req_addr  output  32  fetch address; equals fetch_pc.
- icache_resp_valid  input  1  single-cycle response pulse, at least 1 cycle after the request.
- icache_resp_instr  input  32  instruction word, valid with icache_resp_valid.
- issue_valid  output  1  queue head valid.
- issue_instr  output  32  queue head instruction.
- issue_pc  output  32  queue head PC.
- issue_ready  input  1  decoder accepts the head this cycle.
- redirect_valid  input  1  back-end misprediction or jump flush.
- redirect_pc  input  32  new fetch PC.
- queue_count  output  log2(QUEUE_DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, while rst_in=1):
  - state=S_IDLE, fetch_pc=RESET_PC, head=tail=count=0.
  - All outputs 0; icache_req_valid is gated low by rst_in.
- rdy_in=0:
  - No state, pointer, PC or queue change.
  - icache_req_valid=0.
  - Incoming icache_resp_valid is ignored; the cache must not respond while rdy_in=0.
- FSM states: S_IDLE, S_WAIT, S_DROP. At most one request is outstanding.
- S_IDLE:
  - Combinational: icache_req_valid = rdy_in & !redirect_valid & (count < QUEUE_DEPTH).
  - When asserted, go to S_WAIT; icache_req_addr = fetch_pc.
- S_WAIT, on icache_resp_valid (no redirect this cycle):
  - Push {icache_resp_instr, fetch_pc} at tail; go to S_IDLE.
  - Next PC: if instr[6:0]=7'b1101111 (JAL), fetch_pc += J-imm, where J-imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}.
  - Otherwise fetch_pc += 4. All PC arithmetic is modulo 2^32.
  - No other opcode changes the PC here.
- Room check at request time is sufficient: occupancy only decreases between request and response.
- Issue:
  - issue_valid = (count != 0); issue_instr and issue_pc come from the head entry combinationally.
  - Pop when issue_valid & issue_ready & !redirect_valid.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority, when rdy_in=1):
  - Queue flushed (head=tail=count=0); fetch_pc=redirect_pc; no pop counted.
  - The decoder must ignore any issue handshake in a redirect cycle.
  - S_IDLE: stay in S_IDLE; no request this cycle.
  - S_WAIT without response this cycle: go to S_DROP.
  - S_WAIT with response this cycle: response discarded; go to S_IDLE.
  - S_DROP: stay in S_DROP; fetch_pc updated to the latest redirect_pc.
- S_DROP: no request; on icache_resp_valid, discard the response (no push, no PC change) and go to S_IDLE.
- Wrap-around: head and tail wrap at QUEUE_DEPTH. count distinguishes full (=QUEUE_DEPTH) from empty (=0).

Test Plan:
- Reset, cache with 1-cycle latency returning addi (32'h00100093), issue_ready=1:
  - Requests at 0x0, 0x4, 0x8 on every other cycle.
  - issue_pc sequence 0x0, 0x4, 0x8; queue_count stays at most 1.
- JAL forward and backward:
  - At PC 0x10, resp 32'h0200006F → next request 0x30.
  - At 0x40, resp 32'hFF1FF06F → next request 0x30.
- Full queue, issue_ready=0:
  - After 8 responses queue_count=8 and no further icache_req_valid.
  - One cycle of issue_ready=1 pops one entry; a request is issued the following cycle.
  - Pop order matches push order across tail wrap.
- Redirect mid-flight:
  - Request to 0x8, redirect to 0x100 one cycle later, response two cycles after that → response dropped, queue_count=0.
  - Next request address 0x100.
- Redirect coincident with icache_resp_valid and issue_ready=1, queue holding 3 entries:
  - No push, no pop, queue_count=0.
  - Next cycle: S_IDLE, request 0x100.
- rdy_in=0 for 3 cycles in S_WAIT with 2 entries, then async rst_in pulse mid-S_WAIT:
  - While frozen: outputs and queue_count unchanged.
  - After reset: count=0, next request RESET_PC.
